// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC AD-bus cycle engine.
//   bus_state_t   : phase sequence of one bus transaction
//   T_*_DEFAULT   : default phase lengths in clock cycles
//   RW_READ/WRITE : encoding of the rw command bit
//   phase_cycles  : maps a configured phase length to the cycles actually run
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_HOLD,
    DATA_SETUP,
    DATA_STROBE,
    DATA_HOLD,
    RECOVER
  } bus_state_t;

  localparam int unsigned T_SU_DEFAULT  = 2;
  localparam int unsigned T_PW_DEFAULT  = 10;
  localparam int unsigned T_HD_DEFAULT  = 2;
  localparam int unsigned T_REC_DEFAULT = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // A zero-length phase would never expire; it runs as a single cycle instead.
  function automatic int unsigned phase_cycles(input int unsigned p);
    return (p == 0) ? 1 : p;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_value (phase entry)
//   load_value : phase length in cycles
//   value      : current count, equals 1 in the last cycle of a phase
//   expire     : high in the last cycle of the loaded phase
module rtc_phase_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] value,
  output logic          expire
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign expire = (value == CW'(1));

endmodule

// File: rtl/rtc_bus_cycle.sv
// Two-phase (address, then data) bus-cycle engine for the RTC chip's
// multiplexed 8-bit AD bus, with active-low strobes and programmable timing.
//   clk, reset        : clock, asynchronous active-high reset
//   start, rw         : one-cycle command request, 1 = read / 0 = write
//   addr, wdata       : register address and write data, sampled with start
//   ad_in             : bus value seen through the tri-state buffer
//   ad_out, ad_oe     : value and drive enable for the AD buffer
//   a_d, cs, rd, wr   : address/data select and active-low strobes
//   rdata             : last byte captured by a read
//   busy, done        : transaction in progress, one-cycle completion pulse
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SU  = T_SU_DEFAULT,
  parameter int unsigned T_PW  = T_PW_DEFAULT,
  parameter int unsigned T_HD  = T_HD_DEFAULT,
  parameter int unsigned T_REC = T_REC_DEFAULT,
  parameter int unsigned CW    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

  localparam logic [CW-1:0] LEN_SU  = CW'(phase_cycles(T_SU));
  localparam logic [CW-1:0] LEN_PW  = CW'(phase_cycles(T_PW));
  localparam logic [CW-1:0] LEN_HD  = CW'(phase_cycles(T_HD));
  localparam logic [CW-1:0] LEN_REC = CW'(phase_cycles(T_REC));

  bus_state_t    state, nxt;
  logic          rw_q;
  logic [7:0]    wdata_q;
  logic          is_write;
  logic          tmr_load, tmr_expire;
  logic [CW-1:0] tmr_load_value, tmr_value;

  rtc_phase_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value),
    .expire     (tmr_expire)
  );

  assign is_write = (rw_q == RW_WRITE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:        if (start)      nxt = ADDR_SETUP;
      ADDR_SETUP:  if (tmr_expire) nxt = ADDR_STROBE;
      ADDR_STROBE: if (tmr_expire) nxt = ADDR_HOLD;
      ADDR_HOLD:   if (tmr_expire) nxt = DATA_SETUP;
      DATA_SETUP:  if (tmr_expire) nxt = DATA_STROBE;
      DATA_STROBE: if (tmr_expire) nxt = DATA_HOLD;
      DATA_HOLD:   if (tmr_expire) nxt = RECOVER;
      RECOVER:     if (tmr_expire) nxt = IDLE;
      default:                     nxt = IDLE;
    endcase

    // Every transition enters a new phase, so the timer reloads exactly then.
    tmr_load = (nxt != state);
    unique case (nxt)
      ADDR_SETUP, DATA_SETUP:   tmr_load_value = LEN_SU;
      ADDR_STROBE, DATA_STROBE: tmr_load_value = LEN_PW;
      ADDR_HOLD, DATA_HOLD:     tmr_load_value = LEN_HD;
      RECOVER:                  tmr_load_value = LEN_REC;
      default:                  tmr_load_value = '0;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up cycle-for-cycle with the phase they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rw_q    <= RW_WRITE;
      wdata_q <= '0;
      ad_out  <= '0;
      ad_oe   <= 1'b0;
      a_d     <= 1'b1;
      cs      <= 1'b1;
      rd      <= 1'b1;
      wr      <= 1'b1;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= nxt;

      if (state == IDLE && start) begin
        rw_q    <= rw;
        wdata_q <= wdata;
        ad_out  <= addr;
      end else if (state == ADDR_HOLD && nxt == DATA_SETUP && is_write) begin
        ad_out <= wdata_q;
      end

      // Sample in the final strobe cycle while rd is still low.
      if (state == DATA_STROBE && !is_write && tmr_value == CW'(1)) begin
        rdata <= ad_in;
      end

      a_d   <= !(nxt inside {ADDR_SETUP, ADDR_STROBE, ADDR_HOLD});
      cs    <= !(nxt inside {ADDR_STROBE, DATA_STROBE});
      wr    <= !((nxt == ADDR_STROBE) || (nxt == DATA_STROBE && is_write));
      rd    <= !(nxt == DATA_STROBE && !is_write);
      ad_oe <= (nxt inside {ADDR_SETUP, ADDR_STROBE, ADDR_HOLD}) ||
               (is_write && (nxt inside {DATA_SETUP, DATA_STROBE, DATA_HOLD}));
      busy  <= (nxt != IDLE);
      done  <= (state == RECOVER) && (nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Self-checking bench for rtc_bus_cycle: three instances (default timing,
// all phases 1, all phases 0) share one stimulus stream; a cycle-offset model
// of each transaction predicts every output, plus literal checks on key points.
module tb_rtc_bus_cycle;

  logic       clk, reset, start, rw;
  logic [7:0] addr, wdata, bus_val;
  logic [7:0] ad_in_v[3], ad_out_v[3], rdata_v[3];
  logic       ad_oe_v[3], a_d_v[3], cs_v[3], rd_v[3], wr_v[3], busy_v[3], done_v[3];

  int total = 0;
  int bad   = 0;

  localparam int unsigned SU[3]  = '{2, 1, 1};
  localparam int unsigned PW[3]  = '{10, 1, 1};
  localparam int unsigned HD[3]  = '{2, 1, 1};
  localparam int unsigned REC[3] = '{4, 1, 1};

  rtc_bus_cycle u_def (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .ad_in(ad_in_v[0]), .ad_out(ad_out_v[0]), .ad_oe(ad_oe_v[0]), .a_d(a_d_v[0]),
    .cs(cs_v[0]), .rd(rd_v[0]), .wr(wr_v[0]), .rdata(rdata_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  rtc_bus_cycle #(.T_SU(1), .T_PW(1), .T_HD(1), .T_REC(1)) u_one (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .ad_in(ad_in_v[1]), .ad_out(ad_out_v[1]), .ad_oe(ad_oe_v[1]), .a_d(a_d_v[1]),
    .cs(cs_v[1]), .rd(rd_v[1]), .wr(wr_v[1]), .rdata(rdata_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  rtc_bus_cycle #(.T_SU(0), .T_PW(0), .T_HD(0), .T_REC(0)) u_zero (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .ad_in(ad_in_v[2]), .ad_out(ad_out_v[2]), .ad_oe(ad_oe_v[2]), .a_d(a_d_v[2]),
    .cs(cs_v[2]), .rd(rd_v[2]), .wr(wr_v[2]), .rdata(rdata_v[2]),
    .busy(busy_v[2]), .done(done_v[2])
  );

  // RTC chip model: drives the read byte only while rd is low.
  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign ad_in_v[g] = rd_v[g] ? 8'hEE : bus_val;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Transaction model: offset into the transaction selects the phase.
  bit          m_act[3];
  int unsigned m_off[3];
  logic        m_rw[3];
  logic [7:0]  m_addr[3], m_wd[3], m_rdata[3];
  logic        m_done[3];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int unsigned tot, cap;
      tot = 2*SU[i] + 2*PW[i] + 2*HD[i] + REC[i];
      cap = 2*SU[i] + 2*PW[i] + HD[i] - 1;
      if (reset) begin
        m_act[i] = 0; m_rdata[i] = 8'h00; m_done[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (m_act[i]) begin
          if (m_rw[i] && m_off[i] == cap) m_rdata[i] = bus_val;
          m_off[i]++;
          if (m_off[i] == tot) begin
            m_act[i] = 0; m_done[i] = 1'b1;
          end
        end else if (start) begin
          m_act[i] = 1; m_off[i] = 0; m_rw[i] = rw; m_addr[i] = addr; m_wd[i] = wdata;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int unsigned b1, b2, b3, b4, b5, b6, o;
      bit astb, dstb, wrt;
      logic e_ad, e_cs, e_rd, e_wr, e_oe, e_busy;
      logic [7:0] e_out;
      if (reset) begin
        m_act[i] = 0; m_rdata[i] = 8'h00; m_done[i] = 1'b0;
      end
      b1 = SU[i]; b2 = b1 + PW[i]; b3 = b2 + HD[i];
      b4 = b3 + SU[i]; b5 = b4 + PW[i]; b6 = b5 + HD[i];
      o = m_off[i];
      wrt = (m_rw[i] == 1'b0);
      e_ad = 1; e_cs = 1; e_rd = 1; e_wr = 1; e_oe = 0; e_busy = 0; e_out = 8'h00;
      if (m_act[i]) begin
        astb   = (o >= b1) && (o < b2);
        dstb   = (o >= b4) && (o < b5);
        e_busy = 1;
        e_ad   = (o >= b3);
        e_cs   = !(astb || dstb);
        e_wr   = !(astb || (dstb && wrt));
        e_rd   = !(dstb && !wrt);
        e_oe   = (o < b3) || (wrt && o < b6);
        e_out  = (o < b3) ? m_addr[i] : m_wd[i];
      end
      chk($sformatf("d%0d_a_d", i),   8'(a_d_v[i]),   8'(e_ad));
      chk($sformatf("d%0d_cs", i),    8'(cs_v[i]),    8'(e_cs));
      chk($sformatf("d%0d_rd", i),    8'(rd_v[i]),    8'(e_rd));
      chk($sformatf("d%0d_wr", i),    8'(wr_v[i]),    8'(e_wr));
      chk($sformatf("d%0d_ad_oe", i), 8'(ad_oe_v[i]), 8'(e_oe));
      chk($sformatf("d%0d_busy", i),  8'(busy_v[i]),  8'(e_busy));
      chk($sformatf("d%0d_done", i),  8'(done_v[i]),  8'(m_done[i]));
      chk($sformatf("d%0d_rdata", i), rdata_v[i],     m_rdata[i]);
      if (e_oe) chk($sformatf("d%0d_ad_out", i), ad_out_v[i], e_out);
      total++;
      assert (!(ad_oe_v[i] && !rd_v[i])) else begin
        bad++; $display("FAIL d%0d_oe_vs_rd: ad_oe=%b rd=%b required not both active", i, ad_oe_v[i], rd_v[i]);
      end
      total++;
      assert (!(!rd_v[i] && !wr_v[i])) else begin
        bad++; $display("FAIL d%0d_rd_vs_wr: rd=%b wr=%b required not both low", i, rd_v[i], wr_v[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  int   n_astb, n_dstb, n_rdlow, n_wrdata, n_oedata;

  // Issues one command and follows instance idx until its done pulse.
  task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] d,
                         input int idx, output int blen, output logic first_busy);
    logic got_done;
    rw = r; addr = a; wdata = d; start = 1'b1;
    tick();
    start = 1'b0;
    first_busy = busy_v[idx];
    blen = 0; n_astb = 0; n_dstb = 0; n_rdlow = 0; n_wrdata = 0; n_oedata = 0;
    got_done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done_v[idx]) begin
        got_done = 1'b1;
        break;
      end
      if (busy_v[idx]) blen++;
      if (!a_d_v[idx] && !cs_v[idx] && !wr_v[idx] && ad_out_v[idx] == a) n_astb++;
      if (a_d_v[idx] && !cs_v[idx] && !wr_v[idx] && ad_out_v[idx] == d) n_dstb++;
      if (!rd_v[idx]) n_rdlow++;
      if (a_d_v[idx] && busy_v[idx] && !wr_v[idx]) n_wrdata++;
      if (a_d_v[idx] && busy_v[idx] && ad_oe_v[idx]) n_oedata++;
      tick();
    end
    chk($sformatf("d%0d_done_seen", idx), 8'(got_done), 8'd1);
  endtask

  initial begin
    int   blen, n;
    logic fb;
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; bus_val = 8'h00;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_off[i] = 0; m_rw[i] = 1'b0; m_addr[i] = 8'h00;
      m_wd[i] = 8'h00; m_rdata[i] = 8'h00; m_done[i] = 1'b0;
    end
    tick(); tick();
    chk("rst_rdata", rdata_v[0], 8'h00);
    chk("rst_busy",  8'(busy_v[0]), 8'd0);
    chk("rst_a_d",   8'(a_d_v[0]),  8'd1);
    chk("rst_ad_oe", 8'(ad_oe_v[0]), 8'd0);
    reset = 1'b0;
    tick();

    // Write 0x45 to register 0x21.
    run_txn(1'b0, 8'h21, 8'h45, 0, blen, fb);
    chk("wr_busy_len",    8'(blen),     8'd32);
    chk("wr_addr_strobe", 8'(n_astb),   8'd10);
    chk("wr_data_strobe", 8'(n_dstb),   8'd10);
    chk("wr_rd_low",      8'(n_rdlow),  8'd0);
    chk("wr_oe_data",     8'(n_oedata), 8'd14);
    chk("wr_rdata",       rdata_v[0],   8'h00);
    repeat (3) tick();

    // Read register 0x22, chip returns 0x59.
    bus_val = 8'h59;
    run_txn(1'b1, 8'h22, 8'h00, 0, blen, fb);
    chk("rd_busy_len", 8'(blen),     8'd32);
    chk("rd_rdata",    rdata_v[0],   8'h59);
    chk("rd_rd_low",   8'(n_rdlow),  8'd10);
    chk("rd_wr_data",  8'(n_wrdata), 8'd0);
    chk("rd_oe_data",  8'(n_oedata), 8'd0);
    repeat (3) tick();

    // Second start 5 cycles into a transaction is ignored.
    rw = 1'b0; addr = 8'h50; wdata = 8'h66; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    addr = 8'h77; wdata = 8'h88; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_v[0]) n++;
      tick();
    end
    chk("ign_done_count", 8'(n), 8'd1);
    repeat (3) tick();

    // Back-to-back: second command issued in the done cycle of a write.
    run_txn(1'b0, 8'h31, 8'hA5, 0, blen, fb);
    run_txn(1'b0, 8'h32, 8'h5A, 0, blen, fb);
    chk("b2b_no_gap",   8'(fb),   8'd1);
    chk("b2b_busy_len", 8'(blen), 8'd32);
    repeat (3) tick();

    // Reset in the middle of the address strobe.
    rw = 1'b0; addr = 8'h30; wdata = 8'h12; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre_rst_cs", 8'(cs_v[0]), 8'd0);
    reset = 1'b1;
    #1;
    chk("async_cs",    8'(cs_v[0]),    8'd1);
    chk("async_wr",    8'(wr_v[0]),    8'd1);
    chk("async_rd",    8'(rd_v[0]),    8'd1);
    chk("async_ad_oe", 8'(ad_oe_v[0]), 8'd0);
    tick();
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done_v[0]) n++;
    end
    chk("rst_no_done", 8'(n), 8'd0);
    bus_val = 8'h6A;
    run_txn(1'b1, 8'h23, 8'h00, 0, blen, fb);
    chk("post_rst_busy_len", 8'(blen),   8'd32);
    chk("post_rst_rdata",    rdata_v[0], 8'h6A);
    repeat (3) tick();

    // Minimum timing, and zero-valued timing behaving as one.
    bus_val = 8'h3C;
    run_txn(1'b1, 8'h40, 8'h00, 1, blen, fb);
    chk("min_busy_len",   8'(blen),      8'd7);
    chk("min_rdata",      rdata_v[1],    8'h3C);
    chk("zero_done",      8'(done_v[2]), 8'd1);
    chk("zero_rdata",     rdata_v[2],    8'h3C);
    run_txn(1'b0, 8'h41, 8'h99, 2, blen, fb);
    chk("zero_busy_len",  8'(blen),      8'd7);
    chk("zero_wr_strobe", 8'(n_dstb),    8'd1);
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
